// File: rtl/srio_ireq_arbiter_pkg.sv
// Shared types and widths for the sRIO IREQ packet arbiter.
package srio_arb_pkg;

  localparam int unsigned ARB_MAX_REQ = 4;
  localparam int unsigned GRANT_W     = 2;
  localparam int unsigned DATA_W      = 64;
  localparam int unsigned KEEP_W      = 8;
  localparam int unsigned USER_W      = 32;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  // One AXI4-Stream beat as it crosses the arbiter.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic [USER_W-1:0] user;
    logic              last;
  } beat_t;

endpackage

// File: rtl/srio_ireq_arbiter_if.sv
// AXI4-Stream bundle carrying N lanes packed side by side; N=1 for the core IREQ side.
interface srio_ireq_arbiter_if #(
  parameter int unsigned N = 1
);
  import srio_arb_pkg::*;

  logic [N-1:0]        tvalid;
  logic [N-1:0]        tready;
  logic [N-1:0]        tlast;
  logic [N*DATA_W-1:0] tdata;
  logic [N*KEEP_W-1:0] tkeep;
  logic [N*USER_W-1:0] tuser;

  modport master (output tvalid, tlast, tdata, tkeep, tuser, input tready);
  modport slave  (input tvalid, tlast, tdata, tkeep, tuser, output tready);

endinterface

// File: rtl/srio_ireq_arbiter_rr_pick.sv
// Round-robin winner search starting just after the last granted requester.
module srio_rr_pick
  import srio_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] last_grant,
  output logic [GRANT_W-1:0] win_c,
  output logic               any_c
);

  always_comb begin
    logic found;
    found = 1'b0;
    win_c = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] && (i == ((32'(last_grant) + k) % NUM_REQ))) begin
          found = 1'b1;
          win_c = GRANT_W'(i);
        end
      end
    end
  end

  assign any_c = |req;

endmodule

// File: rtl/srio_ireq_arbiter.sv
// Packet-level round-robin arbiter sharing the sRIO IREQ stream among NUM_REQ sources.
// Define SRIO_ARB_PKT_CNT_EN to build the per-requester completed-packet counters.
module srio_ireq_arbiter
  import srio_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     log_clk,
  input  logic                     log_rst,
  srio_ireq_arbiter_if.slave       s,
  srio_ireq_arbiter_if.master      m,
  output logic [GRANT_W-1:0]       grant,
  output logic                     busy,
  output logic [NUM_REQ*CNT_W-1:0] pkt_cnt
);

  arb_state_e         state, state_d;
  logic [GRANT_W-1:0] grant_d, last_grant, last_grant_d;
  logic               busy_d;
  logic [GRANT_W-1:0] win_c;
  logic               any_c;
  logic               sel_valid_c;
  beat_t              sel_c;
  logic               fire_last_c;

  srio_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req        (s.tvalid),
    .last_grant (last_grant),
    .win_c      (win_c),
    .any_c      (any_c)
  );

  // Lane mux: the granted requester's beat, used only while a packet is owned.
  always_comb begin
    sel_valid_c = 1'b0;
    sel_c       = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant == GRANT_W'(i)) begin
        sel_valid_c = s.tvalid[i];
        sel_c.data  = s.tdata[i*DATA_W +: DATA_W];
        sel_c.keep  = s.tkeep[i*KEEP_W +: KEEP_W];
        sel_c.user  = s.tuser[i*USER_W +: USER_W];
        sel_c.last  = s.tlast[i];
      end
    end
  end

  always_comb begin
    state_d      = state;
    grant_d      = grant;
    busy_d       = busy;
    last_grant_d = last_grant;
    fire_last_c  = 1'b0;
    m.tvalid     = 1'b0;
    m.tlast      = 1'b0;
    m.tdata      = '0;
    m.tkeep      = '0;
    m.tuser      = '0;
    s.tready     = '0;
    unique case (state)
      IDLE: begin
        if (any_c) begin
          grant_d = win_c;
          busy_d  = 1'b1;
          state_d = OWN;
        end
      end
      OWN: begin
        m.tvalid = sel_valid_c;
        m.tlast  = sel_c.last;
        m.tdata  = sel_c.data;
        m.tkeep  = sel_c.keep;
        m.tuser  = sel_c.user;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          s.tready[i] = (grant == GRANT_W'(i)) && m.tready;
        end
        if (sel_valid_c && m.tready && sel_c.last) begin
          fire_last_c  = 1'b1;
          last_grant_d = grant;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // last_grant resets to the top index so requester 0 wins the first arbitration.
  always_ff @(posedge log_clk) begin
    if (log_rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GRANT_W'(NUM_REQ - 1);
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      grant      <= grant_d;
      last_grant <= last_grant_d;
      busy       <= busy_d;
    end
  end

`ifdef SRIO_ARB_PKT_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_REQ];

  always_ff @(posedge log_clk) begin
    if (log_rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else if (fire_last_c) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (grant == GRANT_W'(i)) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign pkt_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end
`else
  logic unused_fire_last;
  assign unused_fire_last = fire_last_c;
  assign pkt_cnt          = '0;
`endif

endmodule

// File: tb/tb_srio_ireq_arbiter.sv
// Scoreboard bench for srio_ireq_arbiter with three requesters and 4-bit counters.
module tb_srio_ireq_arbiter;
  import srio_arb_pkg::*;

  localparam int unsigned NR = 3;
  localparam int unsigned CW = 4;
`ifdef SRIO_ARB_PKT_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic [31:0] user;
    logic        last;
    int          src;
  } tb_beat_t;

  logic               log_clk = 1'b0;
  logic               log_rst = 1'b0;
  logic [GRANT_W-1:0] grant;
  logic               busy;
  logic [NR*CW-1:0]   pkt_cnt;

  srio_ireq_arbiter_if #(.N(NR)) s_if ();
  srio_ireq_arbiter_if #(.N(1))  m_if ();

  srio_ireq_arbiter #(.NUM_REQ(NR), .CNT_W(CW)) dut (
    .log_clk (log_clk),
    .log_rst (log_rst),
    .s       (s_if),
    .m       (m_if),
    .grant   (grant),
    .busy    (busy),
    .pkt_cnt (pkt_cnt)
  );

  always #5 log_clk = ~log_clk;

  tb_beat_t srcq [NR][$];
  tb_beat_t exp_q [$];
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int beats_seen = 0;
  int first_edge = 0;
  int last_edge = 0;
  int bp_start = 0;
  bit prev_last = 1'b0;
  bit bp_mode = 1'b0;
  bit bp_chk = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] exp_cnt(input int n);
    return CNT_ON ? 64'(n % (1 << CW)) : 64'd0;
  endfunction

  function automatic int pending();
    int p = exp_q.size();
    for (int i = 0; i < NR; i++) p += srcq[i].size();
    return p;
  endfunction

  // Present each source's queue head; backpressure mode toggles m_tready every cycle.
  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (srcq[i].size() > 0) begin
        s_if.tvalid[i]          = 1'b1;
        s_if.tlast[i]           = srcq[i][0].last;
        s_if.tdata[i*64 +: 64]  = srcq[i][0].data;
        s_if.tkeep[i*8 +: 8]    = srcq[i][0].keep;
        s_if.tuser[i*32 +: 32]  = srcq[i][0].user;
      end else begin
        s_if.tvalid[i]          = 1'b0;
        s_if.tlast[i]           = 1'b0;
        s_if.tdata[i*64 +: 64]  = 64'd0;
        s_if.tkeep[i*8 +: 8]    = 8'd0;
        s_if.tuser[i*32 +: 32]  = 32'd0;
      end
    end
    m_if.tready[0] = bp_mode ? ~m_if.tready[0] : 1'b1;
  endtask

  task automatic add_pkt(input int src, input int n, input logic [63:0] base, input int n_exp);
    tb_beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = base + 64'(k);
      b.keep = (k == n - 1) ? 8'h0F : 8'hFF;
      b.user = 32'h00A5_0000 | 32'(src);
      b.last = (k == n - 1);
      b.src  = src;
      srcq[src].push_back(b);
      if (k < n_exp) exp_q.push_back(b);
    end
  endtask

  task automatic monitor_beat();
    tb_beat_t e;
    if (exp_q.size() == 0) begin
      check("extra_beat", 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    check("data",  m_if.tdata, e.data);
    check("keep",  64'(m_if.tkeep), 64'(e.keep));
    check("user",  64'(m_if.tuser), 64'(e.user));
    check("last",  64'(m_if.tlast[0]), 64'(e.last));
    check("grant", 64'(grant), 64'(e.src));
    if (beats_seen == 0) first_edge = cyc + 1;
    last_edge = cyc + 1;
    beats_seen++;
  endtask

  task automatic tick();
    logic [NR-1:0] acc;
    logic          fire;
    @(negedge log_clk);
    acc  = s_if.tvalid & s_if.tready;
    fire = m_if.tvalid[0] & m_if.tready[0];
    if (prev_last) check("bubble", 64'(m_if.tvalid[0]), 64'd0);
    if (bp_chk && cyc >= bp_start + 1 && srcq[1].size() > 0) begin
      check("bp_rdy1", 64'(s_if.tready[1]), 64'(m_if.tready[0]));
      check("bp_rdy0", 64'(s_if.tready[0]), 64'd0);
    end
    if (fire) monitor_beat();
    prev_last = fire & m_if.tlast[0];
    @(posedge log_clk);
    cyc++;
    #1;
    for (int i = 0; i < NR; i++) if (acc[i]) void'(srcq[i].pop_front());
    drive();
  endtask

  task automatic run(input int max_cyc);
    for (int t = 0; t < max_cyc && pending() > 0; t++) tick();
    check("drain", 64'(pending()), 64'd0);
  endtask

  task automatic do_reset();
    for (int i = 0; i < NR; i++) srcq[i].delete();
    exp_q.delete();
    bp_mode    = 1'b0;
    bp_chk     = 1'b0;
    prev_last  = 1'b0;
    beats_seen = 0;
    drive();
    log_rst = 1'b1;
    @(posedge log_clk);
    cyc++;
    #1;
    log_rst = 1'b0;
  endtask

  initial begin
    int c0;
    drive();

    // Reset values
    do_reset();
    check("rst_mvalid", 64'(m_if.tvalid[0]), 64'd0);
    check("rst_busy",   64'(busy), 64'd0);
    check("rst_grant",  64'(grant), 64'd0);
    check("rst_sready", 64'(s_if.tready), 64'd0);
    check("rst_cnt",    64'(pkt_cnt), 64'd0);

    // Single requester, 3 beats, zero-latency datapath after one arbitration cycle
    do_reset();
    c0 = cyc;
    add_pkt(0, 3, 64'h0162_0000_0000_1000, 3);
    drive();
    run(20);
    check("t1_beats", 64'(beats_seen), 64'd3);
    check("t1_first", 64'(first_edge), 64'(c0 + 2));
    check("t1_last",  64'(last_edge), 64'(c0 + 4));
    check("t1_cnt0",  64'(pkt_cnt[0*CW +: CW]), exp_cnt(1));

    // Contention: r0 and r1 alternate, 2-beat packets
    do_reset();
    add_pkt(0, 2, 64'h0000_00A0_0000_0000, 2);
    add_pkt(1, 2, 64'h0000_00B0_0000_0000, 2);
    add_pkt(0, 2, 64'h0000_00A1_0000_0000, 2);
    add_pkt(1, 2, 64'h0000_00B1_0000_0000, 2);
    drive();
    run(40);
    check("t2_beats", 64'(beats_seen), 64'd8);
    check("t2_cnt0",  64'(pkt_cnt[0*CW +: CW]), exp_cnt(2));
    check("t2_cnt1",  64'(pkt_cnt[1*CW +: CW]), exp_cnt(2));

    // Backpressure on a 4-beat r1 packet while r0 waits
    do_reset();
    bp_mode = 1'b1;
    add_pkt(1, 4, 64'h0000_0C00_0000_0000, 4);
    bp_start = cyc;
    drive();
    bp_chk = 1'b1;
    tick();
    add_pkt(0, 1, 64'h0000_0D00_0000_0000, 1);
    drive();
    run(40);
    check("t3_beats", 64'(beats_seen), 64'd5);
    check("t3_cnt1",  64'(pkt_cnt[1*CW +: CW]), exp_cnt(1));

    // Reset pulse on beat 2 of 4
    do_reset();
    add_pkt(0, 4, 64'h0000_0E00_0000_0000, 2);
    drive();
    for (int t = 0; t < 20 && beats_seen < 1; t++) tick();
    check("t4_beat1", 64'(beats_seen), 64'd1);
    log_rst = 1'b1;
    tick();
    log_rst = 1'b0;
    check("t4_mvalid", 64'(m_if.tvalid[0]), 64'd0);
    check("t4_busy",   64'(busy), 64'd0);
    check("t4_grant",  64'(grant), 64'd0);
    check("t4_cnt",    64'(pkt_cnt), 64'd0);
    for (int i = 0; i < NR; i++) srcq[i].delete();
    prev_last = 1'b0;
    drive();
    add_pkt(1, 2, 64'h0000_0F00_0000_0000, 2);
    drive();
    run(20);
    check("t4_beats", 64'(beats_seen), 64'd4);
    check("t4_grant1", 64'(grant), 64'd1);

    // Counter wrap: 17 single-beat packets from r2
    do_reset();
    for (int p = 0; p < 17; p++) add_pkt(2, 1, 64'h0000_1000_0000_0000 + 64'(p), 1);
    drive();
    run(200);
    check("t5_beats", 64'(beats_seen), 64'd17);
    check("t5_cnt2",  64'(pkt_cnt[2*CW +: CW]), exp_cnt(17));
    check("t5_cnt0",  64'(pkt_cnt[0*CW +: CW]), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
